// File: rtl/battleship_pkg.sv
// Shared types and helpers for the Battleship board engine.
package battleship_pkg;

  localparam int GRID_N_DEF    = 8;
  localparam int MAX_SHIPS_DEF = 7;

  typedef enum logic [1:0] {
    PLACE = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } board_state_t;

  // Row-major linear cell index for an n-wide board.
  function automatic int cell_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/battleship_board_btn_edge.sv
// Rising-edge detector for an already-synchronised level button.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= btn_i;
    end
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/battleship_board.sv
// Parametrised Battleship board: cursor, ship placement, shot resolution, win detection.
// Optional macro CURSOR_WRAP_EN: cursor wraps at board edges instead of saturating.
module battleship_board
  import battleship_pkg::*;
#(
  parameter int GRID_N    = GRID_N_DEF,
  parameter int MAX_SHIPS = MAX_SHIPS_DEF,
  parameter int COORD_W   = $clog2(GRID_N),
  parameter int SHIP_W    = $clog2(MAX_SHIPS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_up,
  input  logic               move_down,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               place_ship,
  input  logic               fire,
  input  logic               place_en,
  input  logic               fire_en,
  input  logic [SHIP_W-1:0]  amount_of_ships,
  input  logic [COORD_W-1:0] rd_i,
  input  logic [COORD_W-1:0] rd_j,
  output logic [COORD_W-1:0] cursor_i,
  output logic [COORD_W-1:0] cursor_j,
  output logic [SHIP_W-1:0]  ships_placed,
  output logic [SHIP_W-1:0]  ships_remaining,
  output logic               finished_placing,
  output logic               shot_valid,
  output logic               shot_hit,
  output logic               all_sunk,
  output logic               rd_ship,
  output logic               rd_shot
);

  localparam int CELLS = GRID_N * GRID_N;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(GRID_N - 1);
  localparam logic [SHIP_W-1:0]  SHIPS_MAX = SHIP_W'(MAX_SHIPS);

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_PLACE = 4;
  localparam int B_FIRE  = 5;

  logic [5:0] btn_lvl;
  logic [5:0] btn_rise;

  assign btn_lvl = {fire, place_ship, move_right, move_left, move_down, move_up};

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_btn
      btn_edge u_edge (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_lvl[gi]),
        .rise_o (btn_rise[gi])
      );
    end
  endgenerate

  board_state_t       state_q, state_d;
  logic [COORD_W-1:0] ci_q, ci_d;
  logic [COORD_W-1:0] cj_q, cj_d;
  logic [SHIP_W-1:0]  placed_q, placed_d;
  logic [SHIP_W-1:0]  remaining_q, remaining_d;
  logic               finished_q, finished_d;
  logic               valid_q, valid_d;
  logic               hit_q, hit_d;
  logic               sunk_q, sunk_d;
  logic               rd_ship_q, rd_ship_d;
  logic               rd_shot_q, rd_shot_d;
  logic [CELLS-1:0]   ship_map_q, ship_map_d;
  logic [CELLS-1:0]   shot_map_q, shot_map_d;

  logic [SHIP_W-1:0]  k_eff;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   rd_idx;

  assign cur_idx = IDX_W'(cell_idx(int'(ci_q), int'(cj_q), GRID_N));
  assign rd_idx  = IDX_W'(cell_idx(int'(rd_i), int'(rd_j), GRID_N));

  always_comb begin
    k_eff = amount_of_ships;
    if (amount_of_ships == '0) begin
      k_eff = SHIP_W'(1);
    end else if (amount_of_ships > SHIPS_MAX) begin
      k_eff = SHIPS_MAX;
    end
  end

  always_comb begin
    state_d     = state_q;
    ci_d        = ci_q;
    cj_d        = cj_q;
    placed_d    = placed_q;
    remaining_d = remaining_q;
    finished_d  = finished_q;
    valid_d     = 1'b0;
    hit_d       = hit_q;
    sunk_d      = sunk_q;
    ship_map_d  = ship_map_q;
    shot_map_d  = shot_map_q;

    // Opposing edges in the same cycle cancel on their axis.
    if (btn_rise[B_UP] && !btn_rise[B_DOWN]) begin
      if (ci_q != '0) begin
        ci_d = ci_q - 1'b1;
      end else if (WRAP_EN) begin
        ci_d = COORD_MAX;
      end
    end else if (btn_rise[B_DOWN] && !btn_rise[B_UP]) begin
      if (ci_q != COORD_MAX) begin
        ci_d = ci_q + 1'b1;
      end else if (WRAP_EN) begin
        ci_d = '0;
      end
    end

    if (btn_rise[B_LEFT] && !btn_rise[B_RIGHT]) begin
      if (cj_q != '0) begin
        cj_d = cj_q - 1'b1;
      end else if (WRAP_EN) begin
        cj_d = COORD_MAX;
      end
    end else if (btn_rise[B_RIGHT] && !btn_rise[B_LEFT]) begin
      if (cj_q != COORD_MAX) begin
        cj_d = cj_q + 1'b1;
      end else if (WRAP_EN) begin
        cj_d = '0;
      end
    end

    case (state_q)
      PLACE: begin
        if (placed_q >= k_eff) begin
          state_d     = ARMED;
          finished_d  = 1'b1;
          remaining_d = k_eff;
        end else if (btn_rise[B_PLACE] && place_en && !ship_map_q[cur_idx]) begin
          ship_map_d[cur_idx] = 1'b1;
          placed_d            = placed_q + 1'b1;
        end
      end
      ARMED: begin
        if (btn_rise[B_FIRE] && fire_en && !shot_map_q[cur_idx]) begin
          shot_map_d[cur_idx] = 1'b1;
          valid_d             = 1'b1;
          hit_d               = ship_map_q[cur_idx];
          if (ship_map_q[cur_idx] && remaining_q != '0) begin
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == SHIP_W'(1)) begin
              state_d = DONE;
              sunk_d  = 1'b1;
            end
          end
        end
      end
      DONE: begin
        sunk_d = 1'b1;
      end
      default: begin
        state_d = PLACE;
      end
    endcase

    // Query reads the next-state grids so same-cycle writes are visible.
    rd_ship_d = ship_map_d[rd_idx];
    rd_shot_d = shot_map_d[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PLACE;
      ci_q        <= '0;
      cj_q        <= '0;
      placed_q    <= '0;
      remaining_q <= '0;
      finished_q  <= 1'b0;
      valid_q     <= 1'b0;
      hit_q       <= 1'b0;
      sunk_q      <= 1'b0;
      rd_ship_q   <= 1'b0;
      rd_shot_q   <= 1'b0;
      ship_map_q  <= '0;
      shot_map_q  <= '0;
    end else begin
      state_q     <= state_d;
      ci_q        <= ci_d;
      cj_q        <= cj_d;
      placed_q    <= placed_d;
      remaining_q <= remaining_d;
      finished_q  <= finished_d;
      valid_q     <= valid_d;
      hit_q       <= hit_d;
      sunk_q      <= sunk_d;
      rd_ship_q   <= rd_ship_d;
      rd_shot_q   <= rd_shot_d;
      ship_map_q  <= ship_map_d;
      shot_map_q  <= shot_map_d;
    end
  end

  assign cursor_i         = ci_q;
  assign cursor_j         = cj_q;
  assign ships_placed     = placed_q;
  assign ships_remaining  = remaining_q;
  assign finished_placing = finished_q;
  assign shot_valid       = valid_q;
  assign shot_hit         = hit_q;
  assign all_sunk         = sunk_q;
  assign rd_ship          = rd_ship_q;
  assign rd_shot          = rd_shot_q;

endmodule

// File: tb/tb_battleship_board.sv
// Randomised self-checking bench for battleship_board against a game-rule model.
module tb_battleship_board;

  localparam int N    = 8;
  localparam int MAXS = 7;
  localparam int CW   = 3;
  localparam int SW   = 3;

  logic clk = 1'b0;
  logic rst;
  logic move_up, move_down, move_left, move_right, place_ship, fire, place_en, fire_en;
  logic [SW-1:0] amount_of_ships;
  logic [CW-1:0] rd_i, rd_j, cursor_i, cursor_j;
  logic [SW-1:0] ships_placed, ships_remaining;
  logic finished_placing, shot_valid, shot_hit, all_sunk, rd_ship, rd_shot;

  always #5 clk = ~clk;

  battleship_board #(.GRID_N(N), .MAX_SHIPS(MAXS)) dut (
    .clk              (clk),
    .rst              (rst),
    .move_up          (move_up),
    .move_down        (move_down),
    .move_left        (move_left),
    .move_right       (move_right),
    .place_ship       (place_ship),
    .fire             (fire),
    .place_en         (place_en),
    .fire_en          (fire_en),
    .amount_of_ships  (amount_of_ships),
    .rd_i             (rd_i),
    .rd_j             (rd_j),
    .cursor_i         (cursor_i),
    .cursor_j         (cursor_j),
    .ships_placed     (ships_placed),
    .ships_remaining  (ships_remaining),
    .finished_placing (finished_placing),
    .shot_valid       (shot_valid),
    .shot_hit         (shot_hit),
    .all_sunk         (all_sunk),
    .rd_ship          (rd_ship),
    .rd_shot          (rd_shot)
  );

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  always @(negedge clk) if (shot_valid) pulse_cnt++;

  // Reference model: game state as plain integers and 2-D arrays.
  int mi, mj, placed, remaining, mstate, exp_pulses;
  bit mhit, mfin;
  bit mship[N][N];
  bit mshot[N][N];

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int kval(input int a);
    if (a == 0) return 1;
    if (a > MAXS) return MAXS;
    return a;
  endfunction

  function automatic int step(input int v, input int dir);
`ifdef CURSOR_WRAP_EN
    return (v + dir + N) % N;
`else
    if (v + dir < 0 || v + dir > N - 1) return v;
    return v + dir;
`endif
  endfunction

  task automatic model_reset();
    mi = 0; mj = 0; placed = 0; remaining = 0; mstate = 0; mhit = 0; mfin = 0;
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) begin
        mship[a][b] = 0;
        mshot[a][b] = 0;
      end
  endtask

  task automatic model_settle();
    if (mstate == 0 && placed >= kval(int'(amount_of_ships))) begin
      mstate = 1;
      remaining = kval(int'(amount_of_ships));
      mfin = 1;
    end
  endtask

  task automatic check_all();
    chk("cursor_i", int'(cursor_i), mi);
    chk("cursor_j", int'(cursor_j), mj);
    chk("ships_placed", int'(ships_placed), placed);
    chk("ships_remaining", int'(ships_remaining), remaining);
    chk("finished_placing", int'(finished_placing), int'(mfin));
    chk("all_sunk", int'(all_sunk), int'(mstate == 2));
    chk("shot_hit", int'(shot_hit), int'(mhit));
    chk("shot_pulses", pulse_cnt, exp_pulses);
  endtask

  task automatic act(input bit u, input bit d, input bit l, input bit r, input bit p, input bit f);
    @(negedge clk);
    move_up = u; move_down = d; move_left = l; move_right = r; place_ship = p; fire = f;
    @(negedge clk);
    move_up = 0; move_down = 0; move_left = 0; move_right = 0; place_ship = 0; fire = 0;
    repeat (3) @(negedge clk);
    #1;
    if (mstate == 0 && p && place_en && !mship[mi][mj]) begin
      mship[mi][mj] = 1;
      placed++;
    end else if (mstate == 1 && f && fire_en && !mshot[mi][mj]) begin
      mshot[mi][mj] = 1;
      mhit = mship[mi][mj];
      exp_pulses++;
      if (mhit) begin
        remaining--;
        if (remaining == 0) mstate = 2;
      end
    end
    if (u && !d) mi = step(mi, -1);
    if (d && !u) mi = step(mi, 1);
    if (l && !r) mj = step(mj, -1);
    if (r && !l) mj = step(mj, 1);
    model_settle();
    check_all();
  endtask

  task automatic goto_cell(input int ti, input int tj);
    for (int s = 0; s < N && mi != ti; s++) act(ti < mi, ti > mi, 0, 0, 0, 0);
    for (int s = 0; s < N && mj != tj; s++) act(0, 0, tj < mj, tj > mj, 0, 0);
  endtask

  task automatic do_read(input int ri, input int rj);
    @(negedge clk);
    rd_i = CW'(ri); rd_j = CW'(rj);
    @(negedge clk);
    #1;
    chk("rd_ship", int'(rd_ship), int'(mship[ri][rj]));
    chk("rd_shot", int'(rd_shot), int'(mshot[ri][rj]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    move_up = 0; move_down = 0; move_left = 0; move_right = 0; place_ship = 0; fire = 0;
    @(negedge clk);
    rst = 0;
    #1;
    model_reset();
    check_all();
  endtask

  task automatic set_amount(input int a);
    @(negedge clk);
    amount_of_ships = SW'(a);
    repeat (3) @(negedge clk);
    #1;
    model_settle();
    check_all();
  endtask

  initial begin
    rst = 1; move_up = 0; move_down = 0; move_left = 0; move_right = 0;
    place_ship = 0; fire = 0; place_en = 1; fire_en = 1;
    amount_of_ships = 2; rd_i = 0; rd_j = 0;
    exp_pulses = 0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    do_read(0, 0);

    // Cursor navigation, held button, edges and opposing presses.
    repeat (3) act(0, 1, 0, 0, 0, 0);
    repeat (2) act(0, 0, 0, 1, 0, 0);
    @(negedge clk); move_down = 1;
    repeat (10) @(negedge clk);
    move_down = 0;
    repeat (2) @(negedge clk);
    #1;
    mi = step(mi, 1);
    check_all();
    goto_cell(N - 1, N - 1);
    act(0, 1, 0, 1, 0, 0);
    act(1, 1, 0, 0, 0, 0);
    act(0, 0, 1, 1, 0, 0);

    // Two-ship game: duplicate placement, miss, hit, repeat shot, win.
    goto_cell(1, 1);
    act(0, 0, 0, 0, 1, 0);
    act(0, 0, 0, 0, 1, 0);
    goto_cell(2, 2);
    act(0, 0, 0, 0, 1, 0);
    goto_cell(0, 0);
    act(0, 0, 0, 0, 0, 1);
    goto_cell(1, 1);
    act(0, 0, 0, 0, 0, 1);
    act(0, 0, 0, 0, 0, 1);
    do_read(1, 1);
    goto_cell(2, 2);
    act(0, 0, 0, 0, 1, 1);
    act(0, 0, 0, 0, 1, 1);

    // Fleet size clamping: 0 -> 1 ship, max -> MAXS ships.
    do_reset();
    set_amount(0);
    goto_cell(3, 3);
    act(0, 0, 0, 0, 1, 0);
    act(0, 0, 0, 0, 0, 1);
    do_reset();
    set_amount(MAXS);
    goto_cell(1, 0);
    for (int s = 0; s < MAXS; s++) begin
      act(0, 0, 0, 0, 1, 0);
      act(0, 0, 0, 1, 0, 0);
    end

    // Reset coinciding with a fire edge in ARMED suppresses the pulse.
    @(negedge clk);
    fire = 1; rst = 1;
    @(negedge clk);
    fire = 0; rst = 0;
    repeat (3) @(negedge clk);
    #1;
    model_reset();
    check_all();
    do_read(1, 1);

    // Randomised play against the model.
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      place_en = ($urandom_range(0, 9) != 0);
      fire_en  = ($urandom_range(0, 9) != 0);
      if (mstate == 2 && $urandom_range(0, 3) == 0) do_reset();
      else if (r < 50) act($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                           $urandom_range(0, 1), 0, 0);
      else if (r < 68) act(0, 0, 0, 0, 1, 0);
      else if (r < 88) act(0, 0, 0, 0, 0, 1);
      else if (r < 92) act(0, 0, 0, 0, 1, 1);
      else if (r < 95) set_amount($urandom_range(0, 7));
      else if (r < 99) do_read($urandom_range(0, N - 1), $urandom_range(0, N - 1));
      else do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/battleship_board.md
Name: battleship_board

Overview:
- Parametrised board engine for the Battleship game: N×N ship/shot grid, cursor, ship placement, shot resolution, win detection.
- Successor to the fixed 8×8, single-ship-count logic; board size and fleet size are generics.
- Sits between the game FSM (which drives place/fire enables) and the VGA renderer (which reads cells through a registered query port).

Parameters:
- GRID_N, 8, board side length in cells (2..16).
- MAX_SHIPS, 7, maximum fleet size (1..GRID_N*GRID_N-1).
- COORD_W, $clog2(GRID_N), coordinate width (derived, do not override).
- SHIP_W, $clog2(MAX_SHIPS+1), ship-count width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- move_up, move_down, move_left, move_right  in  1 each  level buttons, already synchronised; edge-detected inside.
- place_ship  in  1  level; rising edge = place at cursor.
- fire  in  1  level; rising edge = shoot at cursor.
- place_en  in  1  FSM is in placement state.
- fire_en  in  1  FSM is in player-turn state.
- amount_of_ships  in  SHIP_W  requested fleet size.
- rd_i, rd_j  in  COORD_W each  render query coordinates.
- cursor_i, cursor_j  out  COORD_W each  cursor row/column.
- ships_placed  out  SHIP_W  ships placed so far.
- ships_remaining  out  SHIP_W  unsunk ships.
- finished_placing  out  1  fleet complete (level).
- shot_valid  out  1  one-cycle pulse: shot resolved.
- shot_hit  out  1  result of last shot; held until next shot_valid.
- all_sunk  out  1  victory (level).
- rd_ship, rd_shot  out  1 each  cell contents at (rd_i, rd_j), 1-cycle latency.

Behaviour:
- Reset:
  - States: PLACE.
  - Cursor = (0,0).
  - All counters and all outputs = 0.
  - Both grids (GRID_N² bits each: ship_map, shot_map) cleared in the same cycle.
- Button edges: registered previous value per button; action occurs in the cycle after the 0→1 sample. Held buttons act once.
- Cursor:
  - Up decrements i, down increments i, left decrements j, right increments j.
  - Up+down together: i unchanged. Left+right together: j unchanged.
  - Vertical and horizontal edges in the same cycle both apply.
  - Edge behaviour is set by the optional feature.
  - Moves are allowed in all states.
- Effective fleet size K = amount_of_ships clamped to 1..MAX_SHIPS. K is sampled continuously in PLACE and latched on the PLACE→ARMED transition.
- State PLACE:
  - place_ship edge with place_en=1 on an empty cell: set ship_map, ships_placed+1.
  - Edge on an occupied cell, or with place_en=0: ignored.
  - When ships_placed==K: next cycle finished_placing=1, ships_remaining=K, go to ARMED.
  - Further place edges: ignored.
- State ARMED:
  - fire edge with fire_en=1 on an unshot cell: set shot_map.
  - Next cycle: shot_valid=1, shot_hit=ship_map[cell].
  - On a hit: ships_remaining−1.
  - Fire on an already-shot cell: no pulse, no change.
  - ships_remaining reaching 0 → DONE.
- State DONE:
  - all_sunk=1; fire and place ignored.
  - Exit only through rst.
- place_ship and fire edges in the same cycle: only the action matching the current state is taken.
- Read port: rd_ship/rd_shot are registered from the grids. They reflect writes made in or before the query cycle.
- rst mid-game: returns to PLACE with empty grids in one cycle; any pending shot_valid is suppressed.
- Counters never wrap: saturate at K and at 0.

Optional Feature:
- Macro CURSOR_WRAP_EN.
- Defined: cursor wraps at edges, e.g. i=GRID_N−1 with down → 0, and j=0 with left → GRID_N−1.
- Undefined: cursor saturates at 0 and GRID_N−1; a move past the edge is ignored.

Decomposition:
- Package battleship_pkg holds:
  - state enum board_state_t {PLACE, ARMED, DONE};
  - default GRID_N and MAX_SHIPS constants;
  - function cell_idx(i,j) = i*GRID_N+j.
- One sub-module, btn_edge: registered rising-edge detector, instantiated six times.

Test Plan:
- rst, then 3 down edges + 2 right edges → cursor (3,2); hold down 10 cycles → one move only.
- GRID_N=8, cursor (7,7), down+right: with CURSOR_WRAP_EN → (0,0); without → stays (7,7). up+down together → i unchanged.
- amount_of_ships=2; place at (1,1) twice, then at (2,2) → ships_placed goes 1,1,2; finished_placing=1; ships_remaining=2.
- amount_of_ships=0 → K=1 after one placement; amount_of_ships=MAX_SHIPS+… saturated value → K=MAX_SHIPS.
- ARMED with ships at (1,1),(2,2):
  - fire (0,0) → shot_valid pulse, shot_hit=0;
  - fire (1,1) → hit, ships_remaining=1;
  - fire (1,1) again → no pulse;
  - fire (2,2) → all_sunk=1.
- rst asserted during ARMED → next cycle state PLACE, counters 0; rd_ship/rd_shot read 0 at (1,1).
